mem_stream_reader: RTL

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_stream_reader_if.sv | 29 ++
 rtl/mem_stream_reader.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_stream_reader_if.sv
// Bundle of control, memory-port and output-stream signals for mem_stream_reader.
// master: the reader itself; slave: the environment (controller, memory, consumer).
interface mem_stream_reader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  start, base_addr, length, mem_q, out_ready,
      output busy, done, mem_address, mem_wren, mem_data, out_data, out_valid
   );

   modport slave (
      output start, base_addr, length, mem_q, out_ready,
      input  busy, done, mem_address, mem_wren, mem_data, out_data, out_valid
   );
endinterface

// File: rtl/mem_stream_reader.sv
// Burst reader: streams `length` words from a single-port synchronous-read
// memory, starting at base_addr and wrapping at the top of the address space,
// through a small credit-controlled output FIFO.
module mem_stream_reader #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clock,
   input  logic                reset,
   mem_stream_reader_if.master bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                            state;
   logic [ADDR_W:0]                   remaining;
   logic                              inflight;
   logic [CNT_W-1:0]                  count;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_q;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_nxt;
   logic [CNT_W:0]                    occupancy;
   logic [CNT_W-1:0]                  wr_idx;
   logic                              valid;
   logic                              pop;
   logic                              push;
   logic                              issue;
   logic                              last;

   assign valid         = (count != '0);
   assign bus.out_valid = valid;
   assign bus.out_data  = fifo_q[0];
   assign bus.mem_wren  = 1'b0;
   assign bus.mem_data  = '0;

   // Credit check, issue decision and next FIFO contents (head always at entry 0)
   always_comb begin
      pop       = valid && bus.out_ready;
      push      = inflight;
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
      issue     = (state == RUN) && (remaining != '0) &&
                  (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
      last      = (state == RUN) && pop && (remaining == '0) && !inflight &&
                  (count == CNT_W'(1));
      wr_idx    = pop ? (count - CNT_W'(1)) : count;
      fifo_nxt  = fifo_q;
      if (pop) begin
         for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
            fifo_nxt[i] = fifo_q[i + 1];
         end
      end
      if (push) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) == wr_idx) begin
               fifo_nxt[i] = bus.mem_q;
            end
         end
      end
   end

   // Burst control FSM: capture request, step address per issue, finish on last transfer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.mem_address <= '0;
         remaining       <= '0;
         inflight        <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         inflight <= issue;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.length != '0) begin
                     state           <= RUN;
                     bus.busy        <= 1'b1;
                     bus.mem_address <= bus.base_addr;
                     remaining       <= bus.length;
                  end else begin
                     bus.done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  bus.mem_address <= bus.mem_address + ADDR_W'(1);
                  remaining       <= remaining - (ADDR_W + 1)'(1);
               end
               if (last) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output FIFO storage and occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fifo_q <= '0;
         count  <= '0;
      end else begin
         fifo_q <= fifo_nxt;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule
